seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 6, number of multiplexed digits (legal range 2..8).
REQ-002 SHALL have parameter BRIGHT_W, default 3, width of brightness code; dwell per digit = 2^BRIGHT_W cycles.
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1, inverts seg at output when 1.
REQ-004 SHALL have parameter SEL_ACTIVE_LOW, default 1, inverts sel at output when 1.
REQ-005 SHALL have port clk_1k  input  1  scan clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  input  1  level; 1 = scanning, 0 = display dark.
REQ-008 SHALL have port load  input  1  one-cycle strobe capturing data_in, dp_in, lz_en.
REQ-009 SHALL have port data_in  input  4*N_DIGITS  hex nibbles; digit i = data_in[4i+3:4i], digit N_DIGITS-1 most significant.
REQ-010 SHALL have port dp_in  input  N_DIGITS  decimal point per digit.
REQ-011 SHALL have port lz_en  input  1  leading-zero suppression enable.
REQ-012 SHALL have port bright  input  BRIGHT_W  duty code, sampled at each digit-slot start.
REQ-013 SHALL have port seg  output  8  segments, bit0=a..bit6=g, bit7=dp, registered.
REQ-014 SHALL have port sel  output  N_DIGITS  one-hot digit select, sel[i] drives digit i, registered.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-016 SHALL implement FSM IDLE/SCAN; IDLE->SCAN when en=1; SCAN->IDLE same cycle en=0 is sampled.
REQ-017 SHALL, in IDLE, drive seg all-off and sel all-inactive (polarity-adjusted); counters held at zero.
REQ-018 SHALL scan digits from N_DIGITS-1 down to 0, wrapping to N_DIGITS-1; each slot exactly 2^BRIGHT_W cycles.
REQ-019 SHALL, on load, capture inputs into pending register; pending copies to display shadow at frame boundary (slot of digit 0 ending) or immediately while in IDLE.
REQ-020 SHALL, when load coincides with frame boundary, place the newly loaded data directly in the shadow.
REQ-021 SHALL keep shadow unchanged if no load occurs; zero shadow after reset.
REQ-022 SHALL enable digit during slot cycles where dwell count <= latched bright; other cycles sel inactive, seg off.
REQ-023 SHALL decode nibble 0-F to standard hex glyphs (A,b,C,d,E,F); dp bit from shadow dp.
REQ-024 SHALL, with lz_en=1, blank digits above highest non-zero nibble (dp still shown); digit 0 never blanked; all-zero shows single "0".
REQ-025 SHALL present seg/sel one cycle after internal digit/dwell state (fixed latency 1).
REQ-026 SHALL pulse frame_done in the cycle following the last dwell cycle of digit 0; never in IDLE.
REQ-027 SHALL keep sel strictly one-hot or all-inactive on every cycle, including en transitions.

Reset
REQ-028 SHALL, on rst_n low, asynchronously force IDLE, counters 0, pending/shadow 0, seg all-off, sel all-inactive, frame_done 0.
REQ-029 SHALL, on reset mid-frame, discard pending load; first frame after release starts at digit N_DIGITS-1.

Structure
REQ-030 SHALL place segment glyph constants (16 entries), FSM state encoding and bit-index constants in shared package seg_pkg.
REQ-031 SHALL instantiate one combinational sub-module seg7_hex_decode (nibble, dp -> 8-bit active-high segments).
REQ-032 SHALL apply polarity inversion only at output registers.

Verification
REQ-033 Defaults, load data_in=24'h012345, dp_in=0, lz_en=0, bright=7 -> sel cycles digit5..0, seg (active-low) 8'hC0,F9,A4,B0,99,92, 8 cycles each, frame_done every 48 cycles.
REQ-034 lz_en=1, data_in=24'h0000A0 -> digits 5..2 dark, digit1 shows "A" (8'h88), digit0 shows "0".
REQ-035 bright=1 -> each digit active 2 of 8 cycles, dark 6; bright=0 -> 1 of 8.
REQ-036 load 24'h111111 mid-frame at digit3 -> current frame completes with old data; new data first appears at digit5 of next frame.
REQ-037 en dropped mid-slot -> next cycle seg/sel inactive, no frame_done; re-enable restarts at digit5.
REQ-038 rst_n asserted asynchronously mid-scan -> outputs inactive before next clk_1k edge; shadow reads 0 after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// FSM state encoding, segment bit positions and the hex glyph table.
package seg_pkg;

    // Scan controller FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    // Bit positions inside the 8-bit segment bus.
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high glyphs (g..a), entry 15 first so that GLYPH_TABLE[n] is nibble n.
    // 0 1 2 3 4 5 6 7 8 9 A b C d E F
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Look up the active-high glyph for one hex nibble.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        return GLYPH_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment decoder (active-high, dp in bit 7).
module seg7_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    // Table lookup for the glyph, decimal point passed straight through.
    always_comb begin
        seg              = '0;
        seg[SEG_G:SEG_A] = hex_glyph(nibble);
        seg[SEG_DP]      = dp;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment display scanner. Digits are scanned from the
// most significant down to digit 0, each slot lasting 2^BRIGHT_W cycles,
// with a duty-cycle brightness control, leading-zero suppression and a
// pending/shadow register pair so that new data only lands on a frame edge.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS       = 6,
    parameter int BRIGHT_W       = 3,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                  clk_1k,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lz_en,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [7:0]            seg,
    output logic [N_DIGITS-1:0]   sel,
    output logic                  frame_done
);

    localparam int DIG_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [DIG_W-1:0]    SLOT_LAST  = DIG_W'(N_DIGITS - 1);
    localparam logic [BRIGHT_W-1:0] DWELL_LAST = '1;

    // XOR masks: applying them to an active-high pattern gives the pin level,
    // and applying them to all-zero gives the "off" level used in reset/idle.
    localparam logic [7:0]          SEG_POL = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] SEL_POL = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    scan_state_t            state_q,      state_d;
    logic [DIG_W-1:0]       slot_q,       slot_d;       // 0 = digit N_DIGITS-1
    logic [BRIGHT_W-1:0]    dwell_q,      dwell_d;
    logic [BRIGHT_W-1:0]    bright_q,     bright_d;     // brightness of current slot

    logic [4*N_DIGITS-1:0]  pend_data_q,  pend_data_d;
    logic [N_DIGITS-1:0]    pend_dp_q,    pend_dp_d;
    logic                   pend_lz_q,    pend_lz_d;
    logic                   pend_valid_q, pend_valid_d;

    logic [4*N_DIGITS-1:0]  shad_data_q,  shad_data_d;
    logic [N_DIGITS-1:0]    shad_dp_q,    shad_dp_d;
    logic                   shad_lz_q,    shad_lz_d;

    logic [7:0]             seg_q,        seg_d;
    logic [N_DIGITS-1:0]    sel_q,        sel_d;
    logic                   frame_done_q, frame_done_d;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic [DIG_W-1:0]    digit_idx;
    logic [N_DIGITS-1:0] nib_nonzero;
    logic [DIG_W-1:0]    top_idx;
    logic [3:0]          cur_nibble;
    logic                cur_dp;
    logic [7:0]          dec_seg;
    logic [7:0]          lit_seg;
    logic [N_DIGITS-1:0] sel_hot;
    logic                scanning;
    logic                slot_end;
    logic                frame_end;
    logic                digit_on;
    logic                blank_digit;

    // Slot counter runs upward from zero; the displayed digit counts down.
    assign digit_idx  = SLOT_LAST - slot_q;
    assign cur_nibble = shad_data_q[4*int'(digit_idx) +: 4];
    assign cur_dp     = shad_dp_q[digit_idx];
    assign sel_hot    = N_DIGITS'(1) << digit_idx;

    assign scanning  = (state_q == ST_SCAN) && en;
    assign slot_end  = (dwell_q == DWELL_LAST);
    assign frame_end = scanning && slot_end && (slot_q == SLOT_LAST);
    assign digit_on  = scanning && (dwell_q <= bright_q);

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_nz
            assign nib_nonzero[gi] = |shad_data_q[4*gi +: 4];
        end
    endgenerate

    // Highest digit holding a non-zero nibble (0 when all are zero, so digit 0 always shows).
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (nib_nonzero[i]) begin
                top_idx = DIG_W'(i);
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble (cur_nibble),
        .dp     (cur_dp),
        .seg    (dec_seg)
    );

    // Leading-zero blanking removes the glyph but keeps the decimal point.
    assign blank_digit = shad_lz_q && (digit_idx > top_idx);
    assign lit_seg     = blank_digit ? {dec_seg[SEG_DP], 7'b0} : dec_seg;

    // Next-state logic for the FSM, counters, load registers and outputs.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        dwell_d      = dwell_q;
        bright_d     = bright_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_lz_d    = pend_lz_q;
        pend_valid_d = pend_valid_q;
        shad_data_d  = shad_data_q;
        shad_dp_d    = shad_dp_q;
        shad_lz_d    = shad_lz_q;

        case (state_q)
            ST_IDLE: begin
                slot_d   = '0;
                dwell_d  = '0;
                bright_d = bright;          // first slot uses the value seen on entry
                if (en) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    slot_d  = '0;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + BRIGHT_W'(1);
                    if (slot_end) begin
                        bright_d = bright;  // resample at the start of each slot
                        slot_d   = (slot_q == SLOT_LAST) ? '0 : slot_q + DIG_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = '0;
                dwell_d = '0;
            end
        endcase

        if (load) begin
            pend_data_d  = data_in;
            pend_dp_d    = dp_in;
            pend_lz_d    = lz_en;
            pend_valid_d = 1'b1;
        end

        // Shadow updates only when the display is dark or a frame just ended,
        // so a frame is never drawn with a mix of old and new data. A load on
        // the same edge goes straight through, since pend_*_d already holds it.
        if ((state_q == ST_IDLE) || frame_end) begin
            if (pend_valid_d) begin
                shad_data_d = pend_data_d;
                shad_dp_d   = pend_dp_d;
                shad_lz_d   = pend_lz_d;
            end
            pend_valid_d = 1'b0;
        end

        seg_d        = (digit_on ? lit_seg : 8'h00) ^ SEG_POL;
        sel_d        = (digit_on ? sel_hot : '0)    ^ SEL_POL;
        frame_done_d = frame_end;
    end

    // Single register stage for FSM, counters, data registers and outputs.
    always_ff @(posedge clk_1k or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            slot_q       <= '0;
            dwell_q      <= '0;
            bright_q     <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_lz_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            shad_data_q  <= '0;
            shad_dp_q    <= '0;
            shad_lz_q    <= 1'b0;
            seg_q        <= SEG_POL;
            sel_q        <= SEL_POL;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            dwell_q      <= dwell_d;
            bright_q     <= bright_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_lz_q    <= pend_lz_d;
            pend_valid_q <= pend_valid_d;
            shad_data_q  <= shad_data_d;
            shad_dp_q    <= shad_dp_d;
            shad_lz_q    <= shad_lz_d;
            seg_q        <= seg_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign sel        = sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (default parameters). A frame-level
// reference model predicts seg/sel/frame_done for every clock.
module tb_seg_scan_ctrl;

    logic        clk_1k = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b0;
    logic        load   = 1'b0;
    logic [23:0] data_in = '0;
    logic [5:0]  dp_in   = '0;
    logic        lz_en   = 1'b0;
    logic [2:0]  bright  = '0;
    logic [7:0]  seg;
    logic [5:0]  sel;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_ctrl dut (
        .clk_1k     (clk_1k),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .bright     (bright),
        .seg        (seg),
        .sel        (sel),
        .frame_done (frame_done)
    );

    always #5 clk_1k = ~clk_1k;

    // Active-low hex glyphs 0..F as seen on the pins.
    logic [7:0] gl_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: scan position within a 48-cycle frame plus data registers.
    bit          m_scan;
    int          m_pos;
    int          m_bsl;
    logic [23:0] m_pd, m_sd;
    logic [5:0]  m_pdp, m_sdp;
    bit          m_plz, m_slz, m_pv;
    logic [7:0]  e_seg;
    logic [5:0]  e_sel;
    bit          e_fd;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_scan = 0; m_pos = 0; m_bsl = 0;
        m_pd = '0; m_sd = '0; m_pdp = '0; m_sdp = '0;
        m_plz = 0; m_slz = 0; m_pv = 0;
    endtask

    function automatic logic [7:0] glyph_of(input int digit);
        logic [7:0] g;
        int top;
        top = 0;
        for (int i = 0; i < 6; i++) if (m_sd[4*i +: 4] != 4'h0) top = i;
        if (m_slz && digit > top) g = 8'hFF;
        else g = gl_tab[m_sd[4*digit +: 4]];
        if (m_sdp[digit]) g[7] = 1'b0;
        return g;
    endfunction

    // Advance the model by one clock given the inputs sampled at that edge.
    task automatic model_step(input bit t_en, input bit t_load, input logic [23:0] t_data,
                              input logic [5:0] t_dp, input bit t_lz, input logic [2:0] t_br);
        bit copy;
        int digit, dwell;
        e_seg = 8'hFF; e_sel = 6'h3F; e_fd = 0; copy = 0;
        if (m_scan && t_en) begin
            digit = 5 - m_pos / 8;
            dwell = m_pos % 8;
            if (dwell <= m_bsl) begin
                e_seg = glyph_of(digit);
                e_sel = ~(6'b000001 << digit);
            end
            if (m_pos == 47) begin e_fd = 1; copy = 1; end
            m_pos = (m_pos + 1) % 48;
            if (m_pos % 8 == 0) m_bsl = int'(t_br);
        end else if (m_scan) begin
            m_scan = 0;
        end else begin
            copy = 1;
            if (t_en) begin m_scan = 1; m_pos = 0; m_bsl = int'(t_br); end
        end
        if (t_load) begin m_pd = t_data; m_pdp = t_dp; m_plz = t_lz; m_pv = 1; end
        if (copy && m_pv) begin m_sd = m_pd; m_sdp = m_pdp; m_slz = m_plz; m_pv = 0; end
    endtask

    int fd_count;

    // Drive one cycle of inputs, clock, then compare outputs against the model.
    task automatic tick(input bit t_en, input bit t_load, input logic [23:0] t_data,
                        input logic [5:0] t_dp, input bit t_lz, input logic [2:0] t_br);
        en = t_en; load = t_load; data_in = t_data; dp_in = t_dp; lz_en = t_lz; bright = t_br;
        @(posedge clk_1k);
        model_step(t_en, t_load, t_data, t_dp, t_lz, t_br);
        #1;
        check_val("seg", 32'(seg), 32'(e_seg));
        check_val("sel", 32'(sel), 32'(e_sel));
        check_val("frame_done", 32'(frame_done), 32'(e_fd));
        if (frame_done) fd_count++;
    endtask

    task automatic run(input int n, input bit t_en, input logic [2:0] t_br, input bit t_lz);
        for (int i = 0; i < n; i++) tick(t_en, 1'b0, 24'h0, 6'h0, t_lz, t_br);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk_1k);
        #1;
        check_val("reset_seg", 32'(seg), 32'h0000_00FF);
        check_val("reset_sel", 32'(sel), 32'h0000_003F);
        check_val("reset_fd", 32'(frame_done), 32'h0);
        #3 rst_n = 1'b1;

        // Plain hex scan at full brightness, two full frames counted.
        tick(1'b0, 1'b1, 24'h012345, 6'h00, 1'b0, 3'd7);
        tick(1'b1, 1'b0, 24'h0, 6'h00, 1'b0, 3'd7);
        fd_count = 0;
        run(96, 1'b1, 3'd7, 1'b0);
        check_val("frames_in_96", 32'(fd_count), 32'd2);
        run(20, 1'b1, 3'd7, 1'b0);

        // Leading-zero suppression (load while dark), then the display resumes.
        tick(1'b0, 1'b0, 24'h0, 6'h00, 1'b0, 3'd7);
        tick(1'b0, 1'b1, 24'h0000A0, 6'h00, 1'b1, 3'd7);
        run(60, 1'b1, 3'd7, 1'b0);
        tick(1'b0, 1'b1, 24'h000000, 6'h05, 1'b1, 3'd7);
        run(60, 1'b1, 3'd7, 1'b0);

        // Dimmed duty cycles.
        run(60, 1'b1, 3'd1, 1'b0);
        run(60, 1'b1, 3'd0, 1'b0);

        // Mid-frame load: must wait for the frame boundary.
        run(10, 1'b1, 3'd7, 1'b0);
        tick(1'b1, 1'b1, 24'h111111, 6'h00, 1'b0, 3'd7);
        run(80, 1'b1, 3'd7, 1'b0);

        // Randomised traffic.
        begin
            logic [2:0] br;
            br = 3'($urandom_range(0, 7));
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 29) == 0) br = 3'($urandom_range(0, 7));
                tick($urandom_range(0, 59) != 0, $urandom_range(0, 24) == 0,
                     24'($urandom), 6'($urandom), 1'($urandom), br);
            end
        end

        // Asynchronous reset in the middle of a scan, with a pending load.
        run(30, 1'b1, 3'd7, 1'b0);
        tick(1'b1, 1'b1, 24'hABCDEF, 6'h3F, 1'b0, 3'd7);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_seg", 32'(seg), 32'h0000_00FF);
        check_val("async_rst_sel", 32'(sel), 32'h0000_003F);
        check_val("async_rst_fd", 32'(frame_done), 32'h0);
        model_reset();
        #2 rst_n = 1'b1;
        run(60, 1'b1, 3'd7, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
